cameralink_multi_tap_line_reader: RTL and testbench
===================================================

Name: cameralink_multi_tap_line_reader

Overview:
- sys_clk-domain read controller for N per-channel Camera Link pixel FIFOs; covers base, medium and full configurations with one parametrised block.
- Owns the frame-arming state machine and the FIFO reset/write-allow control.
- Reads one line per burst once all enabled FIFOs reach prog_full, and produces a merged pixel word with frame and line framing.
- Adds runtime channel masking, stall/underflow detection and a line counter.

Parameters:
- NUM_CH, 3: number of channel FIFOs (1..3).
- CH_W, 24: FIFO data width per channel.
- PIX_PER_CH, 2: pixels carried per FIFO word.
- LW_W, 16: width of line_width and the pixel counter.
- STALL_MAX, 255: maximum consecutive empty cycles inside a line before the line is aborted.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous reset, active-high
- locked  in  1  all deserialiser MMCMs locked (already synchronised)
- ch_en  in  NUM_CH  channel enable mask
- fval_sync  in  NUM_CH  per-channel FVAL (already synchronised)
- camera_in_progress  in  1  downstream DMA busy
- line_width  in  LW_W  pixels per line
- fifo_prog_full  in  NUM_CH  per-channel prog_full (already synchronised)
- fifo_empty  in  NUM_CH  per-channel empty (read-domain)
- fifo_dout  in  NUM_CH*CH_W  concatenated FIFO data, channel 0 in the LSBs
- fifo_rd_en  out  1  common read enable
- fifo_rst  out  1  FIFO reset
- wr_allow  out  1  write gate toward the write domain
- pixel_data_o  out  NUM_CH*CH_W  merged pixel word
- pixel_vld  out  1  pixel_data_o valid
- new_frame  out  1  one-cycle frame-start pulse
- frame_valid  out  1  all enabled FVALs high
- line_done  out  1  one-cycle end-of-line pulse
- line_cnt  out  16  lines read in the current frame
- err_stall  out  1  sticky stall error
- state_o  out  2  current FSM state

Behaviour:
- Reset values: state=UNLOCK; fifo_rst=1; fifo_rd_en, wr_allow, pixel_vld, new_frame, frame_valid, line_done, err_stall=0; pixel_data_o=0; line_cnt=0.
- Enabled-set terms: allF = AND over enabled channels of fval_sync; noF = no enabled fval_sync high; allPF, anyE defined likewise over prog_full and empty.
- Channel latch: ch_en_q loaded from ch_en only in UNLOCK and SYNC. ch_en_q=0 is treated as channel 0 only.
- step = popcount(ch_en_q) * PIX_PER_CH, evaluated at LW_W bits.
- FSM, 2-bit encoding:
  - UNLOCK(0): fifo_rst=1. Go to SYNC when locked.
  - SYNC(1): fifo_rst=1. Set internal seen_f when allF. Go to ARMED when seen_f & noF & ~camera_in_progress. Entry is therefore always at a frame boundary.
  - ARMED(2): fifo_rst=0, wr_allow=1. Go to HOLD when noF & camera_in_progress.
  - HOLD(3): fifo_rst=0, wr_allow=1. Go to SYNC (clearing seen_f) on a registered falling edge of camera_in_progress.
  - Any state: ~locked for one cycle forces UNLOCK on the next cycle and aborts any line read. This has priority over every other transition.
- frame_valid is registered from allF, giving 1-cycle latency.
- new_frame is asserted for one cycle when frame_valid rises while state=ARMED; line_cnt clears on the same cycle.
- Line reader (active in ARMED/HOLD while frame_valid is high):
  - Idle with allPF: set reading, pix_cnt=0.
  - fifo_rd_en = reading & ~anyE, combinational.
  - Each fifo_rd_en: pix_cnt += step. If pix_cnt+step >= line_width, clear reading, pulse line_done on the next cycle, and increment line_cnt (saturating at 16'hFFFF).
  - No read occurs without a real rd_en, so counting is exact across empty stalls.
  - reading & anyE: stall_cnt increments; it clears on any rd_en. When stall_cnt reaches STALL_MAX, set err_stall and abort the line (reading=0, no line_done).
  - line_width=0: the line reads exactly one word.
- Output pipeline:
  - FIFO read latency is 1.
  - pixel_data_o is registered on rd_en_d, giving pixel_vld 2 cycles after fifo_rd_en.
  - Disabled channels' slices are forced to 0.
- new_frame coinciding with a start condition: new_frame wins, and the line starts no earlier than the next cycle.
- err_stall clears only on sys_rst or on a transition into UNLOCK.

Test Plan:
- Reset then locked=1; ch_en=3'b011; FVAL pulses high then low with camera_in_progress=0 -> SYNC then ARMED; fifo_rst falls and wr_allow rises on ARMED entry.
- In ARMED, FVAL rises -> frame_valid high after 1 cycle and new_frame exactly one cycle high.
- ch_en=011, PIX_PER_CH=2, line_width=16; all enabled prog_full high, FIFOs never empty -> 4 consecutive fifo_rd_en, 4 pixel_vld delayed by 2 cycles, 1 line_done, line_cnt=1.
- Same line with fifo_empty[1] high for 3 cycles mid-line -> rd_en gaps of 3 cycles, still exactly 4 reads, err_stall=0.
- STALL_MAX=8 with empty held 8 cycles mid-line -> err_stall=1, no line_done; err_stall stays set until locked drops.
- locked dropped mid-line -> UNLOCK next cycle, fifo_rd_en=0, fifo_rst=1. Changing ch_en=001 during ARMED is ignored until re-entry into SYNC; afterwards step=2 and channel 1–2 data slices read 0.

Source files
------------

// File: rtl/cameralink_multi_tap_line_reader.sv
// Read side of the Camera Link channel FIFOs.
// Handles frame arming, FIFO reset/write gating, line-burst reads and the
// merged pixel output with frame/line framing and stall detection.

// Per-channel output slice: captures one FIFO word and zeroes it when the
// channel is masked off.
module cameralink_ch_slice #(
    parameter int CH_W = 24
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            load,
    input  logic            en,
    input  logic [CH_W-1:0] din,
    output logic [CH_W-1:0] dout
);

    // Capture the word returned by the FIFO one cycle after the read.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            dout <= '0;
        else if (load)
            dout <= en ? din : '0;
    end

endmodule

module cameralink_multi_tap_line_reader #(
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 24,
    parameter int PIX_PER_CH = 2,
    parameter int LW_W       = 16,
    parameter int STALL_MAX  = 255
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   locked,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [NUM_CH-1:0]      fval_sync,
    input  logic                   camera_in_progress,
    input  logic [LW_W-1:0]        line_width,
    input  logic [NUM_CH-1:0]      fifo_prog_full,
    input  logic [NUM_CH-1:0]      fifo_empty,
    input  logic [NUM_CH*CH_W-1:0] fifo_dout,
    output logic                   fifo_rd_en,
    output logic                   fifo_rst,
    output logic                   wr_allow,
    output logic [NUM_CH*CH_W-1:0] pixel_data_o,
    output logic                   pixel_vld,
    output logic                   new_frame,
    output logic                   frame_valid,
    output logic                   line_done,
    output logic [15:0]            line_cnt,
    output logic                   err_stall,
    output logic [1:0]             state_o
);

    localparam int SC_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_SYNC   = 2'd1,
        S_ARMED  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] ch_en_q, mask;
    logic              all_f, no_f, all_pf, any_e;
    logic              seen_f, cip_d, cip_fall;
    logic              in_run, frame_start, start, last, line_end, enter_unlock;
    logic              reading;
    logic [LW_W-1:0]   pix_cnt, n_en, step;
    logic [LW_W:0]     pix_sum;
    logic [SC_W-1:0]   stall_cnt;
    logic [1:0]        vld_pipe;

    // An empty latched mask still reads channel 0 so the block never goes dead.
    assign mask   = (ch_en_q == '0) ? NUM_CH'(1) : ch_en_q;
    assign all_f  = &(fval_sync | ~mask);
    assign no_f   = ~|(fval_sync & mask);
    assign all_pf = &(fifo_prog_full | ~mask);
    assign any_e  = |(fifo_empty & mask);

    // Pixels consumed per read: enabled channels times pixels per word.
    always_comb begin
        n_en = '0;
        for (int i = 0; i < NUM_CH; i++)
            n_en = n_en + LW_W'(mask[i]);
        step = n_en * LW_W'(PIX_PER_CH);
    end

    assign cip_fall     = cip_d & ~camera_in_progress;
    assign in_run       = (state == S_ARMED) || (state == S_HOLD);
    assign fifo_rst     = (state == S_UNLOCK) || (state == S_SYNC);
    assign wr_allow     = in_run;
    assign state_o      = state;
    assign enter_unlock = (state != S_UNLOCK) && (state_nxt == S_UNLOCK);

    // Next-state logic; loss of lock overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_UNLOCK: if (locked) state_nxt = S_SYNC;
            S_SYNC:   if (seen_f && no_f && !camera_in_progress) state_nxt = S_ARMED;
            S_ARMED:  if (no_f && camera_in_progress) state_nxt = S_HOLD;
            S_HOLD:   if (cip_fall) state_nxt = S_SYNC;
            default:  state_nxt = S_UNLOCK;
        endcase
        if (!locked)
            state_nxt = S_UNLOCK;
    end

    // State register plus frame-arming bookkeeping.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= S_UNLOCK;
            seen_f  <= 1'b0;
            cip_d   <= 1'b0;
            ch_en_q <= '0;
        end else begin
            state <= state_nxt;
            cip_d <= camera_in_progress;
            // seen_f only lives inside SYNC, so every SYNC visit starts clean.
            if (state != S_SYNC)
                seen_f <= 1'b0;
            else if (all_f)
                seen_f <= 1'b1;
            // Mask is frozen once armed so a frame never changes shape mid-way.
            if (state == S_UNLOCK || state == S_SYNC)
                ch_en_q <= ch_en;
        end
    end

    assign frame_start = (state == S_ARMED) && all_f && !frame_valid && locked;

    // Frame framing: registered FVAL and the one-cycle frame-start pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_valid <= 1'b0;
            new_frame   <= 1'b0;
        end else begin
            frame_valid <= all_f;
            new_frame   <= frame_start;
        end
    end

    // A pending frame start takes precedence over opening a line.
    assign start      = in_run && locked && frame_valid && !reading && all_pf && !new_frame;
    assign fifo_rd_en = reading && !any_e;
    assign pix_sum    = {1'b0, pix_cnt} + {1'b0, step};
    assign last       = pix_sum >= {1'b0, line_width};
    assign line_end   = locked && in_run && fifo_rd_en && last;

    // Line reader: counts pixels only on real reads, aborts on long stalls.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            reading   <= 1'b0;
            pix_cnt   <= '0;
            stall_cnt <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (!locked || !in_run) begin
                reading   <= 1'b0;
                stall_cnt <= '0;
            end else if (start) begin
                reading   <= 1'b1;
                pix_cnt   <= '0;
                stall_cnt <= '0;
            end else if (fifo_rd_en) begin
                stall_cnt <= '0;
                if (last) begin
                    reading   <= 1'b0;
                    line_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_sum[LW_W-1:0];
                end
            end else if (reading && any_e) begin
                if (stall_cnt >= SC_W'(STALL_MAX - 1)) begin
                    reading   <= 1'b0;
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end

    // Line counter: cleared at frame start, saturating increment per line.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            line_cnt <= '0;
        else if (frame_start)
            line_cnt <= '0;
        else if (line_end && line_cnt != 16'hFFFF)
            line_cnt <= line_cnt + 16'd1;
    end

    // Sticky stall error; only a fresh trip through UNLOCK clears it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            err_stall <= 1'b0;
        else if (enter_unlock)
            err_stall <= 1'b0;
        else if (locked && in_run && reading && any_e && !start &&
                 stall_cnt >= SC_W'(STALL_MAX - 1))
            err_stall <= 1'b1;
    end

    // Valid pipeline: [0] = data on the FIFO bus, [1] = data on the output.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[0], fifo_rd_en};
    end

    assign pixel_vld = vld_pipe[1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cameralink_ch_slice #(.CH_W(CH_W)) u_slice (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .load    (vld_pipe[0]),
            .en      (mask[c]),
            .din     (fifo_dout[c*CH_W +: CH_W]),
            .dout    (pixel_data_o[c*CH_W +: CH_W])
        );
    end

endmodule

// File: tb/tb_cameralink_multi_tap_line_reader.sv
// Directed bench for the Camera Link line reader with a read-side model.
module tb_cameralink_multi_tap_line_reader;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 24;
    localparam int PIX    = 2;
    localparam int LW_W   = 16;
    localparam int SMAX   = 8;
    localparam int DW     = NUM_CH * CH_W;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              locked;
    logic [NUM_CH-1:0] ch_en, fval_sync, fifo_prog_full, fifo_empty;
    logic              camera_in_progress;
    logic [LW_W-1:0]   line_width;
    logic [DW-1:0]     fifo_dout = '0;
    logic              fifo_rd_en, fifo_rst, wr_allow, pixel_vld, new_frame;
    logic              frame_valid, line_done, err_stall;
    logic [DW-1:0]     pixel_data_o;
    logic [15:0]       line_cnt;
    logic [1:0]        state_o;

    cameralink_multi_tap_line_reader #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .PIX_PER_CH(PIX), .LW_W(LW_W), .STALL_MAX(SMAX)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .locked(locked), .ch_en(ch_en),
        .fval_sync(fval_sync), .camera_in_progress(camera_in_progress),
        .line_width(line_width), .fifo_prog_full(fifo_prog_full),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .fifo_rst(fifo_rst), .wr_allow(wr_allow), .pixel_data_o(pixel_data_o),
        .pixel_vld(pixel_vld), .new_frame(new_frame), .frame_valid(frame_valid),
        .line_done(line_done), .line_cnt(line_cnt), .err_stall(err_stall),
        .state_o(state_o)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO word k: channel c carries {A0+c, k}.
    function automatic logic [DW-1:0] word(input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int c = 0; c < NUM_CH; c++)
            w[c*CH_W +: CH_W] = {8'(8'hA0 + c), 16'(k)};
        return w;
    endfunction

    function automatic logic [DW-1:0] masked(input logic [DW-1:0] w, input logic [NUM_CH-1:0] m);
        logic [DW-1:0] r;
        r = w;
        for (int c = 0; c < NUM_CH; c++)
            if (!m[c]) r[c*CH_W +: CH_W] = '0;
        return r;
    endfunction

    // FIFO emulation: one-cycle read latency, sequential word numbering.
    int k_f = 0;
    always @(posedge sys_clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= word(k_f);
            k_f       <= k_f + 1;
        end
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0, k_m = 0, rd_in_line = 0, line_first = 0, line_last = 0, base = 0;
    bit chk_on = 0, ld_pend = 0;
    logic [NUM_CH-1:0] exp_mask = 3'b011;
    int q_due[$];
    logic [DW-1:0] q_dat[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reads needed for a line: ceil(width/step), at least one.
    function automatic int exp_reads();
        int st;
        logic [NUM_CH-1:0] m;
        m  = (exp_mask == '0) ? NUM_CH'(1) : exp_mask;
        st = $countones(m) * PIX;
        if (line_width == 0) return 1;
        return (int'(line_width) + st - 1) / st;
    endfunction

    // One cycle: compare outputs against the model at negedge, then advance.
    task automatic step();
        bit due;
        @(negedge sys_clk);
        if (chk_on) begin
            due = (q_due.size() > 0) && (q_due[0] == cyc);
            check("pixel_vld", DW'(pixel_vld), DW'(due));
            if (due) begin
                check("pixel_data", pixel_data_o, q_dat[0]);
                void'(q_due.pop_front());
                void'(q_dat.pop_front());
            end
            check("line_done", DW'(line_done), DW'(ld_pend));
            ld_pend = 0;
            if (fifo_rd_en) begin
                check("rd_while_empty", DW'(fifo_empty & exp_mask), '0);
                q_due.push_back(cyc + 2);
                q_dat.push_back(masked(word(k_m), exp_mask));
                k_m++;
                if (rd_in_line == 0) line_first = cyc;
                line_last = cyc;
                rd_in_line++;
                if (rd_in_line >= exp_reads()) begin
                    ld_pend    = 1;
                    rd_in_line = 0;
                end
            end
        end
        cyc++;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst = 1; locked = 0; ch_en = 3'b011; fval_sync = 0; camera_in_progress = 0;
        line_width = 16; fifo_prog_full = 0; fifo_empty = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_state", DW'(state_o), DW'(0));
        check("rst_fifo_rst", DW'(fifo_rst), DW'(1));
        check("rst_rd_en", DW'(fifo_rd_en), DW'(0));
        check("rst_wr_allow", DW'(wr_allow), DW'(0));
        check("rst_vld", DW'(pixel_vld), DW'(0));
        check("rst_new_frame", DW'(new_frame), DW'(0));
        check("rst_fv", DW'(frame_valid), DW'(0));
        check("rst_err", DW'(err_stall), DW'(0));
        check("rst_data", pixel_data_o, '0);
        check("rst_line_cnt", DW'(line_cnt), DW'(0));

        sys_rst = 0; chk_on = 1;
        step(); check("unlock_hold", DW'(state_o), DW'(0));
        locked = 1;
        step(); check("to_sync", DW'(state_o), DW'(1));
        check("sync_fifo_rst", DW'(fifo_rst), DW'(1));
        fval_sync = 3'b011;
        step(); check("sync_wait_fall", DW'(state_o), DW'(1));
        check("sync_no_new_frame", DW'(new_frame), DW'(0));
        fval_sync = 3'b000;
        step(); check("to_armed", DW'(state_o), DW'(2));
        check("armed_fifo_rst", DW'(fifo_rst), DW'(0));
        check("armed_wr_allow", DW'(wr_allow), DW'(1));

        fval_sync = 3'b011;
        step(); check("fv_rise", DW'(frame_valid), DW'(1));
        check("new_frame_hi", DW'(new_frame), DW'(1));
        check("line_cnt_clr", DW'(line_cnt), DW'(0));
        step(); check("new_frame_lo", DW'(new_frame), DW'(0));

        // Line 1: no stalls, 16 pixels / 4 per read.
        base = k_m; fifo_prog_full = 3'b011;
        step(); fifo_prog_full = 0;
        step(); step();
        check("first_pixel", pixel_data_o, 72'h000000_a10000_a00000);
        repeat (8) step();
        check("l1_reads", DW'(k_m - base), DW'(4));
        check("l1_span", DW'(line_last - line_first), DW'(3));
        check("l1_line_cnt", DW'(line_cnt), DW'(1));

        // Line 2: channel 1 empty for 3 cycles after the first read.
        base = k_m; fifo_prog_full = 3'b011;
        step(); fifo_prog_full = 0;
        step(); fifo_empty = 3'b010;
        repeat (3) step();
        fifo_empty = 0;
        check("l2_gap_reads", DW'(k_m - base), DW'(1));
        repeat (8) step();
        check("l2_reads", DW'(k_m - base), DW'(4));
        check("l2_span", DW'(line_last - line_first), DW'(6));
        check("l2_err", DW'(err_stall), DW'(0));
        check("l2_line_cnt", DW'(line_cnt), DW'(2));

        // Line 3: stall of STALL_MAX cycles aborts the line.
        base = k_m; fifo_prog_full = 3'b011;
        step(); fifo_prog_full = 0;
        step(); fifo_empty = 3'b010;
        repeat (SMAX - 1) step();
        check("l3_err_before", DW'(err_stall), DW'(0));
        step();
        check("l3_err_set", DW'(err_stall), DW'(1));
        fifo_empty = 0; rd_in_line = 0;
        repeat (6) step();
        check("l3_reads", DW'(k_m - base), DW'(1));
        check("l3_line_cnt", DW'(line_cnt), DW'(2));
        check("l3_err_sticky", DW'(err_stall), DW'(1));

        // Line 4: zero width reads a single word.
        line_width = 0; base = k_m; fifo_prog_full = 3'b011;
        step(); fifo_prog_full = 0;
        repeat (5) step();
        check("l4_reads", DW'(k_m - base), DW'(1));
        check("l4_line_cnt", DW'(line_cnt), DW'(3));
        line_width = 16;

        // Mask change while armed is ignored: still 4 pixels per read.
        ch_en = 3'b001; base = k_m; fifo_prog_full = 3'b011;
        step(); fifo_prog_full = 0;
        repeat (8) step();
        check("l5_reads", DW'(k_m - base), DW'(4));
        check("l5_line_cnt", DW'(line_cnt), DW'(4));

        // Lock lost mid-line.
        fifo_prog_full = 3'b011;
        step(); fifo_prog_full = 0;
        step(); locked = 0;
        step();
        check("unlock_state", DW'(state_o), DW'(0));
        check("unlock_rd_en", DW'(fifo_rd_en), DW'(0));
        check("unlock_fifo_rst", DW'(fifo_rst), DW'(1));
        check("unlock_err_clr", DW'(err_stall), DW'(0));
        rd_in_line = 0; locked = 1;
        step(); check("resync", DW'(state_o), DW'(1));
        exp_mask = 3'b001; fval_sync = 3'b001;
        step(); check("resync_wait", DW'(state_o), DW'(1));
        fval_sync = 0;
        step(); check("rearmed", DW'(state_o), DW'(2));

        // New frame coincides with start condition: the line waits.
        base = k_m; fval_sync = 3'b001; fifo_prog_full = 3'b001;
        step(); check("nf2_hi", DW'(new_frame), DW'(1));
        check("nf2_line_cnt", DW'(line_cnt), DW'(0));
        check("nf2_no_rd", DW'(fifo_rd_en), DW'(0));
        step(); check("nf2_lo", DW'(new_frame), DW'(0));
        check("nf2_still_no_rd", DW'(fifo_rd_en), DW'(0));
        step(); check("nf2_rd", DW'(fifo_rd_en), DW'(1));
        fifo_prog_full = 0;
        repeat (12) step();
        check("l6_reads", DW'(k_m - base), DW'(8));
        check("l6_span", DW'(line_last - line_first), DW'(7));
        check("l6_line_cnt", DW'(line_cnt), DW'(1));
        check("l6_masked_slices", DW'(pixel_data_o[DW-1:CH_W]), '0);

        // HOLD and release on falling camera_in_progress.
        fval_sync = 0; camera_in_progress = 1;
        step(); check("to_hold", DW'(state_o), DW'(3));
        check("hold_wr_allow", DW'(wr_allow), DW'(1));
        step(); check("hold_stay", DW'(state_o), DW'(3));
        camera_in_progress = 0;
        step(); check("hold_to_sync", DW'(state_o), DW'(1));
        check("sync_fifo_rst2", DW'(fifo_rst), DW'(1));
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
